// File: rtl/vball_pkg.sv
// Shared types and constants for the graphics ROM read-port arbiter.
package vball_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic REQ_BG = 1'b0;
  localparam logic REQ_SP = 1'b1;

  localparam int unsigned DEF_ADDR_W = 19;

endpackage

// File: rtl/vball_gfx_arb_pick.sv
// Combinational winner select between BG and SP fetchers, blank-dependent
// priority overridden by whichever starvation counter has hit its limit.
module vball_gfx_arb_pick
  import vball_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       bg_req,
  input  logic       sp_req,
  input  logic       hb,
  input  logic [3:0] bg_starve,
  input  logic [3:0] sp_starve,
  output logic       any_req,
  output logic       win
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  always_comb begin
    any_req = bg_req | sp_req;
    win     = REQ_BG;
    if (bg_req && sp_req) begin
      if (sp_starve == STARVE_LIM)      win = REQ_SP;
      else if (bg_starve == STARVE_LIM) win = REQ_BG;
      else                              win = hb ? REQ_SP : REQ_BG;
    end else if (sp_req) begin
      win = REQ_SP;
    end
  end

endmodule

// File: rtl/vball_gfx_arb.sv
// Shares the external graphics ROM read port between the BG tile fetcher and
// the sprite fetcher; fixed latency, one read outstanding at a time.
module vball_gfx_arb
  import vball_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              hb,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic [7:0]        bg_data,
  output logic              bg_valid,
  input  logic              sp_req,
  input  logic [ADDR_W-1:0] sp_addr,
  output logic [7:0]        sp_data,
  output logic              sp_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy
);

  localparam logic [3:0] LAT_LD     = 4'(LATENCY - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          bg_starve_q, bg_starve_d;
  logic [3:0]          sp_starve_q, sp_starve_d;
  logic                win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          bg_data_q, bg_data_d;
  logic [7:0]          sp_data_q, sp_data_d;
  logic                bg_valid_q, bg_valid_d;
  logic                sp_valid_q, sp_valid_d;
  logic                any_req;
  logic                pick_win;

  vball_gfx_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .bg_req   (bg_req),
    .sp_req   (sp_req),
    .hb       (hb),
    .bg_starve(bg_starve_q),
    .sp_starve(sp_starve_q),
    .any_req  (any_req),
    .win      (pick_win)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bg_starve_d = bg_starve_q;
    sp_starve_d = sp_starve_q;
    win_d       = win_q;
    addr_d      = addr_q;
    bg_data_d   = bg_data_q;
    sp_data_d   = sp_data_q;
    bg_valid_d  = 1'b0;
    sp_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = pick_win;
          addr_d  = (pick_win == REQ_SP) ? sp_addr : bg_addr;
          state_d = ISSUE;
          // The other request still being high means this was a contested
          // arbitration, so the loser accrues starvation credit.
          if (pick_win == REQ_SP) begin
            sp_starve_d = '0;
            if (bg_req && bg_starve_q != STARVE_LIM) bg_starve_d = bg_starve_q + 4'd1;
          end else begin
            bg_starve_d = '0;
            if (sp_req && sp_starve_q != STARVE_LIM) sp_starve_d = sp_starve_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (win_q == REQ_SP) begin
            sp_data_d  = mem_data;
            sp_valid_d = 1'b1;
          end else begin
            bg_data_d  = mem_data;
            bg_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bg_starve_q <= '0;
      sp_starve_q <= '0;
      win_q       <= REQ_BG;
      addr_q      <= '0;
      bg_data_q   <= '0;
      sp_data_q   <= '0;
      bg_valid_q  <= 1'b0;
      sp_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bg_starve_q <= bg_starve_d;
      sp_starve_q <= sp_starve_d;
      win_q       <= win_d;
      addr_q      <= addr_d;
      bg_data_q   <= bg_data_d;
      sp_data_q   <= sp_data_d;
      bg_valid_q  <= bg_valid_d;
      sp_valid_q  <= sp_valid_d;
    end
  end

  assign mem_rd   = (state_q == ISSUE);
  assign mem_addr = addr_q;
  assign bg_data  = bg_data_q;
  assign sp_data  = sp_data_q;
  assign bg_valid = bg_valid_q;
  assign sp_valid = sp_valid_q;
  assign busy     = (state_q != IDLE) | bg_valid_q | sp_valid_q;

endmodule

// File: doc/vball_gfx_arb.md
Name: vball_gfx_arb

Overview:
- Shares the single external graphics ROM read port (gfx_read / gfx_addr / gfx_data) between two requesters: the background tile fetcher (BG) and the sprite fetcher (SP).
- Once this block is in place, sprite graphics move out of internal block RAM into the same external memory.
- Fixed-latency read port, one outstanding read at a time.
- Priority depends on blanking, with a starvation guard so neither requester can be locked out.

Parameters:
- ADDR_W, 19, graphics ROM byte-address width.
- LATENCY, 3, clk_sys cycles from mem_rd high to mem_data valid. Legal range 1..15.
- STARVE_MAX, 4, consecutive grants to one requester while the other is waiting, after which the waiting requester is forced to win. Legal range 1..15.

Ports:
- clk_sys, in, 1, system clock; all logic is on its rising edge.
- reset, in, 1, asynchronous, active-high.
- hb, in, 1, horizontal blank from the video timing block.
- bg_req, in, 1, BG read request; held high until bg_valid.
- bg_addr, in, ADDR_W, BG byte address; stable while bg_req is high.
- bg_data, out, 8, BG read data.
- bg_valid, out, 1, one-cycle strobe; bg_data is valid in this cycle.
- sp_req, in, 1, SP read request; same rules as bg_req.
- sp_addr, in, ADDR_W, SP byte address.
- sp_data, out, 8, SP read data.
- sp_valid, out, 1, one-cycle SP data strobe.
- mem_rd, out, 1, one-cycle read strobe to the external port (drives gfx_read).
- mem_addr, out, ADDR_W, read address, held from issue until data capture (drives gfx_addr).
- mem_data, in, 8, external read data (gfx_data).
- busy, out, 1, high while a read is outstanding.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, latency counter 0, starvation counters 0.
- Reset asserted mid-read: the read is abandoned. No valid strobe is produced for it, and a late mem_data is ignored.

States:
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner (see arbitration below), latch its id and address into mem_addr, go to ISSUE.
- ISSUE:
  - mem_rd = 1 for exactly this cycle.
  - Load the latency counter with LATENCY-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, this cycle is the data cycle: capture mem_data into the winner's data register. The winner's valid strobe goes high in the next cycle, together with the return to IDLE.
- busy = 1 in ISSUE and WAIT, and in the cycle valid is high.

Latency and throughput:
- If IDLE samples a request at edge N, mem_rd is high in cycle N+1.
- The valid strobe is high in cycle N+1+LATENCY+1.
- Back-to-back: a request can win in the cycle valid is high. Peak rate is one read every LATENCY+2 cycles.

Handshake:
- Requesters drop req at the edge where they see valid high.
- If req is still high in the next IDLE cycle, that is a new request.
- Data registers hold their value until the next capture for the same requester.
- A requester that drops req before it is granted simply never wins; this is not an error.

Arbitration (evaluated only in IDLE):
- Only one requester high: it wins.
- Both high:
  1. If one starvation counter equals STARVE_MAX, that requester wins.
  2. Otherwise SP wins when hb = 1, and BG wins when hb = 0.
- Starvation counters:
  - The loser's counter increments, saturating at STARVE_MAX, only when both requests were high at the arbitration.
  - The winner's counter clears to 0.
  - Both counters are 4 bits.
- hb and req changes outside IDLE have no effect on the read in flight.

Decomposition:
- Shared package vball_pkg holds:
  - Typedef for the state: IDLE, ISSUE, WAIT.
  - Requester id constants: REQ_BG = 0, REQ_SP = 1.
  - Default ADDR_W.
- One sub-module, vball_gfx_arb_pick: combinational winner select from req, hb and the starvation counters. Kept separate so it can be tested exhaustively on its own.

Test Plan:
- Single BG request, addr 0x12345, LATENCY 3, memory returns 0xA5:
  - mem_rd high in exactly one cycle with mem_addr 0x12345.
  - bg_valid high 4 cycles after mem_rd, with bg_data 0xA5.
  - sp_valid stays 0.
- Both requests high with hb = 0:
  - BG is served first, then SP.
  - With hb = 1, the order is SP first, then BG.
- BG re-requests continuously while SP is held high and hb = 0, STARVE_MAX 4:
  - SP is granted after exactly 4 consecutive BG grants.
  - The SP counter reads 0 afterwards.
- Back-to-back SP requests (req re-raised the cycle after valid):
  - mem_rd strobes exactly LATENCY+2 = 5 cycles apart.
- Reset asserted 1 cycle after mem_rd:
  - All outputs are 0 next cycle.
  - No valid strobe appears, even though mem_data changes later.
  - After reset releases, a fresh BG request completes normally.
- hb toggles while a read is in WAIT:
  - The in-flight grant and its data are unaffected.
  - The new priority applies only at the next IDLE.
